spislaveio: RTL
===============

# spislaveio

SPI target (slave) peripheral for the cpu11 bus, the far end of the SPI link that `spiio` drives as master. It lets the board be clocked by an external SPI master, receiving bytes into a small FIFO and shifting out bytes loaded by the CPU. It maps into a DS decode slot like the other IO blocks, with a level IRQ OR-ed into `cpu_irq`.

## Interface
- `RX_DEPTH`, default 4: RX FIFO depth in bytes (power of two, ≥2).
- `FILL_RESET`, default 8'hFF: reset value of the FILL register.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset; synchronous and active-high.
- `irq` out 1: level interrupt request.
- `AD` in 3: register select.
- `DI` in 8: write data from CPU.
- `DO` out 8: read data to CPU, combinational from `AD` and state.
- `rw` in 1: 1 = read, 0 = write.
- `cs` in 1: access strobe, qualified with vma; acted on at posedge `clk`.
- `ssck` in 1: SPI clock from master, asynchronous.
- `smosi` in 1: SPI data from master.
- `sss` in 1: slave select, active low.
- `smiso` out 1: SPI data to master.
- `smiso_oe` out 1: pad enable for `smiso`, 1 = drive.

## Operation
- Registers (`AD`):
  - 0 DATA: a read returns the RX FIFO head and pops it (head 8'h00 if empty, no pop). A write loads the TX holding register and clears TXE.
  - 1 STATUS (reads): b0 RXNE, b1 RXFULL, b2 TXE, b3 OVR, b4 UDR, b5 BUSY (synced `sss` low), b6 SSEND; b7 = 0. Writing 1 to b3/b4/b6 clears that bit; other write bits are ignored.
  - 2 CTRL (R/W): b0 EN, b1 CPHA, b2 CPOL, b3 IE_RX, b4 IE_TX, b5 IE_ERR, b6 IE_SS, b7 LSBF (1 = LSB first).
  - 3 FILL (R/W): byte sent on underrun.
  - 4–7: read 8'h00; writes ignored.
- Input sync: `ssck`, `smosi` and `sss` each pass through a 2-FF synchronizer; edges are detected on the synchronized copies.
- Edge roles:
  - The leading edge is rising when CPOL=0, falling when CPOL=1.
  - CPHA=0: sample on the leading edge, drive on the trailing edge.
  - CPHA=1: drive on the leading edge, sample on the trailing edge.
- States:
  - IDLE (EN=0 or `sss` high). `smiso_oe`=0 and `bitcnt`=0.
  - ACTIVE (entered on `sss` fall with EN=1).
- Frame start (`sss` fall):
  - Load `txsr` from the holding register if TXE=0, then set TXE=1.
  - If TXE=1, load FILL instead and set UDR.
  - Then `smiso_oe`=1 and `smiso` = first bit (b7, or b0 if LSBF).
- Sample edge: shift synced `smosi` into `rxsr` and increment `bitcnt` (3 bits, wraps).
  - On the wrap from 7 to 0, push `rxsr` into the FIFO. If the FIFO is full, drop the byte and set OVR.
  - Also on that wrap, reload `txsr` using the frame-start rule, including the UDR rule.
- Drive edge: `smiso` ← `txsr` bit selected by `bitcnt` (MSB- or LSB-first order).
- `sss` rise in ACTIVE:
  - Discard the partial byte and set `bitcnt`=0.
  - Set SSEND; set `smiso_oe`=0.
  - Return to IDLE.
  - `txsr` is not returned to the holding register.
- EN cleared mid-frame: same as `sss` rise, except SSEND is not set.
- `irq` = (IE_RX & RXNE) | (IE_TX & TXE) | (IE_ERR & (OVR | UDR)) | (IE_SS & SSEND).
- Simultaneous events:
  - Pop and push in the same cycle: both take effect, count unchanged. When full, the push is accepted and OVR is not set.
  - CPU write to DATA and `txsr` load in the same cycle: the load uses the pre-write holding state (old byte, or FILL with UDR), and the written byte lands in holding with TXE=0.
  - Flag set and write-1-clear in the same cycle: set wins.

## Timing
- Reset values:
  - `irq`=0, `smiso`=0, `smiso_oe`=0.
  - CTRL=8'h00, FILL=FILL_RESET, holding=8'h00, TXE=1.
  - FIFO empty; OVR, UDR and SSEND all 0.
- Pin to action latency: 3 clk (2 sync + 1 edge-detect register).
  - `smiso` changes 3 clk after a drive edge on the `ssck` pin.
  - On frame start, `smiso` is valid 3 clk after `sss` falls.
- Constraints on the master:
  - `ssck` high and low phases ≥ 4 clk.
  - `sss` fall to first `ssck` edge ≥ 4 clk.
- Bus side:
  - `DO` is combinational, with no wait states.
  - Writes and pops take effect at the posedge where `cs`=1.
  - Status reflects them on the next cycle.
- RXNE sets 1 clk after the 8th sample edge is detected.

## Structure
- Shared package holds:
  - register offsets: DATA=0, STAT=1, CTRL=2, FILL=3;
  - STATUS and CTRL bit indices;
  - the SPI mode encoding.
- Sub-module `spislave_rxfifo`: synchronous FIFO, depth `RX_DEPTH`, with push, pop, full, empty and head outputs, reset by `rst`.
- Synchronizers, shifter and register file stay in the top module.

## Test plan
- Mode 0, MSB first, holding=8'hA5; master sends 8'h3C at clk/8 -> master receives 8'hA5, FIFO head 8'h3C, RXNE=1, TXE=1; with IE_RX=1, `irq`=1; a DATA read returns 8'h3C and `irq` drops.
- Mode 3 (CPOL=1, CPHA=1) and LSBF=1, two-byte frame, holding empty, FILL=8'h5A -> master receives 8'h5A twice, UDR=1; writing 8'h10 to STATUS clears UDR.
- Five bytes sent with no reads (RX_DEPTH=4) -> first four bytes retained in order, fifth dropped, OVR=1; a pop and the 5th push in the same cycle -> no OVR, count stays 4.
- `sss` raised after 5 bits -> no push, SSEND=1, `smiso_oe`=0; the next frame receives a full byte correctly.
- `rst` asserted mid-frame -> all registers return to reset values and `smiso_oe`=0 in the next cycle; bus reads give CTRL=8'h00, STATUS=8'h04 with `sss` high.
- DATA write in the same cycle as the byte-complete reload with TXE=1 -> FILL is shifted out, UDR=1, the new byte is sent in the following byte.

Source files
------------

// File: rtl/spislaveio_pkg.sv
// rtl/spislaveio_pkg.sv - shared register map, bit indices and SPI mode encoding for spislaveio
package spislaveio_pkg;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_STAT = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam logic [2:0] REG_FILL = 3'd3;

  localparam int ST_RXNE   = 0;
  localparam int ST_RXFULL = 1;
  localparam int ST_TXE    = 2;
  localparam int ST_OVR    = 3;
  localparam int ST_UDR    = 4;
  localparam int ST_BUSY   = 5;
  localparam int ST_SSEND  = 6;

  localparam int CT_EN     = 0;
  localparam int CT_CPHA   = 1;
  localparam int CT_CPOL   = 2;
  localparam int CT_IE_RX  = 3;
  localparam int CT_IE_TX  = 4;
  localparam int CT_IE_ERR = 5;
  localparam int CT_IE_SS  = 6;
  localparam int CT_LSBF   = 7;

  // Encoded as {CPOL, CPHA}
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic {
    LINK_IDLE   = 1'b0,
    LINK_ACTIVE = 1'b1
  } link_state_e;

  // Bit of a shift byte that goes on the wire at position idx of the frame
  function automatic logic tx_bit(input logic [7:0] sr, input logic [2:0] idx, input logic lsbf);
    return lsbf ? sr[idx] : sr[3'd7 - idx];
  endfunction

endpackage

// File: rtl/spislave_rxfifo.sv
// rtl/spislave_rxfifo.sv - synchronous receive byte FIFO; push while full is accepted only alongside a pop
module spislave_rxfifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          rd_en;
  logic          wr_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spislaveio.sv
// rtl/spislaveio.sv - SPI target peripheral: pin synchronizers, link FSM and shifters, CPU register file
module spislaveio
  import spislaveio_pkg::*;
#(
  parameter int         RX_DEPTH   = 4,
  parameter logic [7:0] FILL_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       irq,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  input  logic       ssck,
  input  logic       smosi,
  input  logic       sss,
  output logic       smiso,
  output logic       smiso_oe
);

  logic [2:0]  ssck_sync;
  logic [1:0]  mosi_sync;
  logic [2:0]  sss_sync;

  link_state_e state;
  logic [7:0]  txsr;
  logic [7:0]  rxsr;
  logic [2:0]  bitcnt;

  logic [7:0]  ctrl;
  logic [7:0]  fill;
  logic [7:0]  hold;
  logic        txe;
  logic        ovr;
  logic        udr;
  logic        ssend;

  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;

  spi_mode_e   mode;
  logic        lsbf;
  logic        sck_rise, sck_fall, sss_rise, sss_fall;
  logic        lead_edge, trail_edge, sample_edge, drive_edge;
  logic        active, running;
  logic        frame_start, abort_ss, abort_en;
  logic        do_sample, do_drive, byte_done, tx_load;
  logic [7:0]  rx_next, tx_next;
  logic        bus_wr, bus_rd, pop, ovr_set;
  logic [7:0]  status;

  // Edges come from the second and third synchronizer stages so every action lands 3 clk after the pin
  assign sck_rise = ssck_sync[1] & ~ssck_sync[2];
  assign sck_fall = ~ssck_sync[1] & ssck_sync[2];
  assign sss_rise = sss_sync[1] & ~sss_sync[2];
  assign sss_fall = ~sss_sync[1] & sss_sync[2];

  assign mode        = spi_mode_e'({ctrl[CT_CPOL], ctrl[CT_CPHA]});
  assign lsbf        = ctrl[CT_LSBF];
  assign lead_edge   = (mode == SPI_MODE0 || mode == SPI_MODE1) ? sck_rise : sck_fall;
  assign trail_edge  = (mode == SPI_MODE0 || mode == SPI_MODE1) ? sck_fall : sck_rise;
  assign sample_edge = (mode == SPI_MODE0 || mode == SPI_MODE2) ? lead_edge : trail_edge;
  assign drive_edge  = (mode == SPI_MODE0 || mode == SPI_MODE2) ? trail_edge : lead_edge;

  assign active      = (state == LINK_ACTIVE);
  assign running     = active & ~sss_rise & ctrl[CT_EN];
  assign frame_start = ~active & sss_fall & ctrl[CT_EN];
  assign abort_ss    = active & sss_rise;
  assign abort_en    = active & ~sss_rise & ~ctrl[CT_EN];
  assign do_sample   = running & sample_edge;
  assign do_drive    = running & drive_edge;
  assign byte_done   = do_sample & (bitcnt == 3'd7);
  assign tx_load     = frame_start | byte_done;

  assign rx_next = lsbf ? {mosi_sync[1], rxsr[7:1]} : {rxsr[6:0], mosi_sync[1]};
  assign tx_next = txe ? fill : hold;

  assign bus_wr  = cs & ~rw;
  assign bus_rd  = cs & rw;
  assign pop     = bus_rd & (AD == REG_DATA) & ~fifo_empty;
  assign ovr_set = byte_done & fifo_full & ~pop;

  spislave_rxfifo #(
    .DEPTH(RX_DEPTH)
  ) u_rxfifo (
    .clk      (clk),
    .rst      (rst),
    .push     (byte_done),
    .push_data(rx_next),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ssck_sync <= 3'b000;
      mosi_sync <= 2'b00;
      sss_sync  <= 3'b111;
      state     <= LINK_IDLE;
      txsr      <= 8'h00;
      rxsr      <= 8'h00;
      bitcnt    <= 3'd0;
      smiso     <= 1'b0;
      smiso_oe  <= 1'b0;
    end else begin
      ssck_sync <= {ssck_sync[1:0], ssck};
      mosi_sync <= {mosi_sync[0], smosi};
      sss_sync  <= {sss_sync[1:0], sss};
      if (frame_start) begin
        state    <= LINK_ACTIVE;
        txsr     <= tx_next;
        bitcnt   <= 3'd0;
        smiso    <= tx_bit(tx_next, 3'd0, lsbf);
        smiso_oe <= 1'b1;
      end else if (abort_ss || abort_en) begin
        // Partial byte is simply forgotten; a full byte always overwrites rxsr
        state    <= LINK_IDLE;
        bitcnt   <= 3'd0;
        smiso_oe <= 1'b0;
      end else if (do_sample) begin
        rxsr   <= rx_next;
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          txsr <= tx_next;
        end
      end else if (do_drive) begin
        smiso <= tx_bit(txsr, bitcnt, lsbf);
      end
    end
  end

  // Order matters: write-1-clear first so flag sets win, DATA write last so it lands after a reload
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl  <= 8'h00;
      fill  <= FILL_RESET;
      hold  <= 8'h00;
      txe   <= 1'b1;
      ovr   <= 1'b0;
      udr   <= 1'b0;
      ssend <= 1'b0;
    end else begin
      if (bus_wr) begin
        case (AD)
          REG_DATA: hold <= DI;
          REG_STAT: begin
            if (DI[ST_OVR])   ovr   <= 1'b0;
            if (DI[ST_UDR])   udr   <= 1'b0;
            if (DI[ST_SSEND]) ssend <= 1'b0;
          end
          REG_CTRL: ctrl <= DI;
          REG_FILL: fill <= DI;
          default: ;
        endcase
      end
      if (tx_load) begin
        if (txe) udr <= 1'b1;
        else     txe <= 1'b1;
      end
      if (ovr_set)  ovr   <= 1'b1;
      if (abort_ss) ssend <= 1'b1;
      if (bus_wr && AD == REG_DATA) txe <= 1'b0;
    end
  end

  always_comb begin
    status            = 8'h00;
    status[ST_RXNE]   = ~fifo_empty;
    status[ST_RXFULL] = fifo_full;
    status[ST_TXE]    = txe;
    status[ST_OVR]    = ovr;
    status[ST_UDR]    = udr;
    status[ST_BUSY]   = ~sss_sync[1];
    status[ST_SSEND]  = ssend;
  end

  always_comb begin
    DO = 8'h00;
    case (AD)
      REG_DATA: DO = fifo_empty ? 8'h00 : fifo_head;
      REG_STAT: DO = status;
      REG_CTRL: DO = ctrl;
      REG_FILL: DO = fill;
      default:  DO = 8'h00;
    endcase
  end

  assign irq = (ctrl[CT_IE_RX]  & ~fifo_empty)
             | (ctrl[CT_IE_TX]  & txe)
             | (ctrl[CT_IE_ERR] & (ovr | udr))
             | (ctrl[CT_IE_SS]  & ssend);

endmodule
